evenparity_rx: RTL and testbench
================================

# evenparity_rx

Bit-serial receiver and checker for the 9-bit even-parity word {data[7:0], parity} produced by the even-parity generator. It deserializes a framed word (start, 9 word bits, stop) from a single-bit line and recomputes even parity. It presents the data byte with parity and framing status over a valid/ready interface and keeps an error counter. It sits at the far end of the parity-protected link, between the line sampler (which supplies a one-cycle bit strobe) and the consuming logic.

## Interface
- CNT_W, 8: width of the saturating error counter.
- DROP_BAD, 0: 1 = frames with a parity or framing error are counted but never presented on the output.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  bit strobe; `sin` is sampled only in cycles where bit_en=1.
- sin  input  1  serial line, idle high.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- err_clr  input  1  synchronous clear of err_cnt and overrun.
- out_data  output  8  received data byte (word bits z[8:1]).
- out_perr  output  1  parity error on the presented word.
- out_ferr  output  1  stop-bit (framing) error on the presented word.
- out_valid  output  1  output word valid.
- overrun  output  1  sticky; a completed frame was lost because the output was still full.
- err_cnt  output  CNT_W  count of errored frames, saturating.
- busy  output  1  high while the FSM is not IDLE.

## Operation
- Frame on the line, one bit per bit_en strobe: start (0), z[8] (data MSB) … z[1] (data LSB), z[0] (parity), stop (1).
- Parity check: word is good when the XOR of z[8:0] is 0, i.e. z[0] = ^data. out_perr = ^z[8:0].
- FSM states and transitions, all moves on bit_en=1 only:
  - IDLE, on sin=0: go to DATA and clear the bit counter. On sin=1: stay in IDLE.
  - DATA: shift sin into a 9-bit register, MSB first. After the 9th bit (counter 0..8, wrapping at 8), go to STOP.
  - STOP, on sin=1: frame complete, ferr=0. On sin=0: frame complete, ferr=1.
  - STOP always returns to IDLE. A low stop bit is never treated as a new start.
- bit_en=0: all state, counter and shift register hold.
- Frame completion in the STOP cycle:
  - If the output register is free, or is being accepted in that same cycle, load out_data/out_perr/out_ferr and set out_valid.
  - Otherwise drop the new frame and set overrun. The held word is unchanged.
  - With DROP_BAD=1, an errored frame is never loaded and never causes overrun.
- Handshake: out_valid stays high and out_data/out_perr/out_ferr stay stable until out_valid && out_ready. out_valid does not depend combinationally on out_ready.
- err_cnt increments by 1 for each completed frame with perr or ferr (counted once even if both are set). It increments regardless of overrun or DROP_BAD and saturates at 2^CNT_W−1.
- err_clr: err_cnt and overrun are cleared.
  - If an error increment occurs in the same cycle, err_cnt becomes 1.
  - If an overrun occurs in the same cycle, overrun becomes 1.
- Reset: all outputs 0 (out_data=0x00, out_valid=0, out_perr=0, out_ferr=0, overrun=0, err_cnt=0, busy=0), FSM in IDLE. Any partial frame is discarded.

## Timing
- Latency: out_valid rises on the clock edge that samples the stop bit, so it is visible in the cycle after the stop-bit strobe.
- Accepting a word and loading a new one in the same cycle: the new word appears in the next cycle, out_valid stays 1, no overrun.
- Minimum frame: 11 bit_en strobes. Back-to-back frames are allowed: a start bit may be sampled on the strobe right after the stop strobe.
- busy rises the cycle after the start bit is sampled and falls the cycle after the stop bit is sampled.
- rst asserted in any cycle takes priority over every other input. The first usable start bit is at the first bit_en after rst deasserts.

## Test plan
- Good frame, data 0xA5, parity 0, out_ready=1: line 0,1,0,1,0,0,1,0,1,0,1 -> out_data=0xA5, out_perr=0, out_ferr=0, one out_valid pulse, err_cnt=0.
- Bad parity, data 0xA5 sent with parity 1; then data 0x01 sent with parity 1 -> first word out_perr=1, err_cnt=1; second word out_perr=0, err_cnt stays 1.
- Framing error, data 0x3C sent with a stop bit of 0 -> out_ferr=1, FSM returns to IDLE, err_cnt=1. With DROP_BAD=1: no out_valid, err_cnt=1.
- Backpressure, out_ready=0, frames 0x11 then 0x22 -> out_data holds 0x11, overrun=1. Raise out_ready -> 0x11 accepted, 0x22 never appears. Pulse err_clr -> overrun=0.
- Saturation with CNT_W=2: five bad-parity frames -> err_cnt sequence 1,2,3,3,3. err_clr together with a sixth bad frame -> err_cnt=1.
- Reset mid-frame: assert rst after 4 data bits -> busy=0, out_valid=0. Then a clean 0x5A frame -> out_data=0x5A, out_perr=0, and no residue from the aborted frame.

Source files
------------

// File: rtl/evenparity_rx.sv
// Bit-serial even-parity word receiver: start, z[8:1] data MSB first, z[0] parity, stop.
// Presents the byte with parity/framing status on a valid/ready port and counts errored frames.
module evenparity_rx #(
   parameter int CNT_W    = 8,
   parameter bit DROP_BAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_en,
   input  logic             sin,
   input  logic             out_ready,
   input  logic             err_clr,
   output logic [7:0]       out_data,
   output logic             out_perr,
   output logic             out_ferr,
   output logic             out_valid,
   output logic             overrun,
   output logic [CNT_W-1:0] err_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

   state_t           state_reg, state_next;
   logic [3:0]       cnt_reg, cnt_next;
   logic [8:0]       shift_reg, shift_next;
   logic [7:0]       data_reg;
   logic             perr_reg, ferr_reg, valid_reg, overrun_reg;
   logic [CNT_W-1:0] err_cnt_reg;

   logic done, frame_perr, frame_ferr, frame_bad, frame_keep;
   logic accept, load, lost, err_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         shift_reg <= 9'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         shift_reg <= shift_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      shift_next = shift_reg;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bit_en && !sin) begin
               state_next = DATA;
               cnt_next   = 4'd0;
            end
         end
         DATA: begin
            if (bit_en) begin
               shift_next = {shift_reg[7:0], sin};
               if (cnt_reg == 4'd8) begin
                  cnt_next   = 4'd0;
                  state_next = STOP;
               end else begin
                  cnt_next = cnt_reg + 4'd1;
               end
            end
         end
         STOP: begin
            // A low stop bit only flags a framing error; it never restarts a frame.
            if (bit_en) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign frame_perr = ^shift_reg;
   assign frame_ferr = ~sin;
   assign frame_bad  = frame_perr | frame_ferr;
   assign frame_keep = (DROP_BAD == 1'b0) || !frame_bad;
   assign accept     = valid_reg && out_ready;
   assign load       = done && frame_keep && (!valid_reg || out_ready);
   assign lost       = done && frame_keep && valid_reg && !out_ready;
   assign err_inc    = done && frame_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg  <= 8'd0;
         perr_reg  <= 1'b0;
         ferr_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else if (load) begin
         data_reg  <= shift_reg[8:1];
         perr_reg  <= frame_perr;
         ferr_reg  <= frame_ferr;
         valid_reg <= 1'b1;
      end else if (accept) begin
         valid_reg <= 1'b0;
      end
   end

   // Clear and a same-cycle event combine so the new event is never lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_reg <= '0;
         overrun_reg <= 1'b0;
      end else begin
         if (err_clr) begin
            err_cnt_reg <= err_inc ? CNT_W'(1) : '0;
         end else if (err_inc && !(&err_cnt_reg)) begin
            err_cnt_reg <= err_cnt_reg + CNT_W'(1);
         end
         if (err_clr) begin
            overrun_reg <= lost;
         end else if (lost) begin
            overrun_reg <= 1'b1;
         end
      end
   end

   assign out_data  = data_reg;
   assign out_perr  = perr_reg;
   assign out_ferr  = ferr_reg;
   assign out_valid = valid_reg;
   assign overrun   = overrun_reg;
   assign err_cnt   = err_cnt_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_evenparity_rx.sv
// Directed bench for evenparity_rx: default, DROP_BAD=1 and CNT_W=2 instances share one stimulus line.
module tb_evenparity_rx;

   logic clk = 1'b0;
   logic rst, bit_en, sin, out_ready, err_clr;

   logic [7:0] m_data, d_data, s_data;
   logic       m_perr, m_ferr, m_valid, m_ovr, m_busy;
   logic       d_perr, d_ferr, d_valid, d_ovr, d_busy;
   logic       s_perr, s_ferr, s_valid, s_ovr, s_busy;
   logic [7:0] m_cnt, d_cnt;
   logic [1:0] s_cnt;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   evenparity_rx #(.CNT_W(8), .DROP_BAD(1'b0)) u_main (
      .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .out_ready(out_ready), .err_clr(err_clr),
      .out_data(m_data), .out_perr(m_perr), .out_ferr(m_ferr), .out_valid(m_valid),
      .overrun(m_ovr), .err_cnt(m_cnt), .busy(m_busy));

   evenparity_rx #(.CNT_W(8), .DROP_BAD(1'b1)) u_drop (
      .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .out_ready(out_ready), .err_clr(err_clr),
      .out_data(d_data), .out_perr(d_perr), .out_ferr(d_ferr), .out_valid(d_valid),
      .overrun(d_ovr), .err_cnt(d_cnt), .busy(d_busy));

   evenparity_rx #(.CNT_W(2), .DROP_BAD(1'b0)) u_sat (
      .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .out_ready(out_ready), .err_clr(err_clr),
      .out_data(s_data), .out_perr(s_perr), .out_ferr(s_ferr), .out_valid(s_valid),
      .overrun(s_ovr), .err_cnt(s_cnt), .busy(s_busy));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the sampling edge.
   task automatic strobe(input logic b);
      sin    = b;
      bit_en = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      sin    = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input logic rdy_stop, input logic clr_stop);
      logic rdy_save;
      strobe(1'b0);
      for (int i = 7; i >= 0; i--) strobe(d[i]);
      strobe(p);
      rdy_save = out_ready;
      if (rdy_stop) out_ready = 1'b1;
      if (clr_stop) err_clr = 1'b1;
      strobe(s);
      out_ready = rdy_save;
      err_clr   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bit_en = 1'b0; sin = 1'b1; out_ready = 1'b1; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_data",  32'(m_data),  32'h0);
      check("rst_valid", 32'(m_valid), 32'h0);
      check("rst_perr",  32'(m_perr),  32'h0);
      check("rst_ferr",  32'(m_ferr),  32'h0);
      check("rst_ovr",   32'(m_ovr),   32'h0);
      check("rst_cnt",   32'(m_cnt),   32'h0);
      check("rst_busy",  32'(m_busy),  32'h0);

      // Good frame 0xA5, parity 0
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
      check("good_valid", 32'(m_valid), 32'h1);
      check("good_data",  32'(m_data),  32'hA5);
      check("good_perr",  32'(m_perr),  32'h0);
      check("good_ferr",  32'(m_ferr),  32'h0);
      check("good_cnt",   32'(m_cnt),   32'h0);
      check("good_busy",  32'(m_busy),  32'h0);
      @(negedge clk);
      check("good_pulse", 32'(m_valid), 32'h0);

      // Bad parity then good 0x01 with parity 1
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
      check("bp1_perr",   32'(m_perr),  32'h1);
      check("bp1_data",   32'(m_data),  32'hA5);
      check("bp1_cnt",    32'(m_cnt),   32'h1);
      check("bp1_dvalid", 32'(d_valid), 32'h0);
      send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      check("bp2_perr",   32'(m_perr),  32'h0);
      check("bp2_data",   32'(m_data),  32'h01);
      check("bp2_cnt",    32'(m_cnt),   32'h1);
      check("bp2_dvalid", 32'(d_valid), 32'h1);
      check("bp2_dcnt",   32'(d_cnt),   32'h1);
      @(negedge clk);

      // Framing error: 0x3C with stop bit 0, then a clean frame right behind it
      do_reset();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      check("fe_ferr",   32'(m_ferr),  32'h1);
      check("fe_perr",   32'(m_perr),  32'h0);
      check("fe_cnt",    32'(m_cnt),   32'h1);
      check("fe_busy",   32'(m_busy),  32'h0);
      check("fe_dvalid", 32'(d_valid), 32'h0);
      check("fe_dcnt",   32'(d_cnt),   32'h1);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
      check("fe2_ferr",  32'(m_ferr),  32'h0);
      check("fe2_data",  32'(m_data),  32'h3C);
      @(negedge clk);

      // Backpressure with overrun, then clear
      do_reset();
      out_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
      check("bk1_valid", 32'(m_valid), 32'h1);
      check("bk1_data",  32'(m_data),  32'h11);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
      check("bk2_data",  32'(m_data),  32'h11);
      check("bk2_valid", 32'(m_valid), 32'h1);
      check("bk2_ovr",   32'(m_ovr),   32'h1);
      out_ready = 1'b1;
      @(negedge clk);
      check("bk_accept", 32'(m_valid), 32'h0);
      repeat (3) @(negedge clk);
      check("bk_no22",   32'(m_valid), 32'h0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("bk_clr_ovr", 32'(m_ovr), 32'h0);
      check("bk_cnt",     32'(m_cnt), 32'h0);

      // Accept and load in the same cycle
      out_ready = 1'b0;
      send_frame(8'h44, 1'b0, 1'b1, 1'b0, 1'b0);
      check("sc1_data", 32'(m_data), 32'h44);
      send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
      check("sc2_data",  32'(m_data),  32'h55);
      check("sc2_valid", 32'(m_valid), 32'h1);
      check("sc2_ovr",   32'(m_ovr),   32'h0);
      out_ready = 1'b1;
      @(negedge clk);

      // Saturation on the CNT_W=2 instance
      do_reset();
      for (int k = 0; k < 5; k++) begin
         send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
         check($sformatf("sat_cnt%0d", k + 1), 32'(s_cnt), (k < 2) ? 32'(k + 1) : 32'd3);
      end
      check("sat_main5", 32'(m_cnt), 32'd5);
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
      check("sat_clr_inc",  32'(s_cnt), 32'd1);
      check("main_clr_inc", 32'(m_cnt), 32'd1);
      @(negedge clk);

      // Reset in the middle of a frame
      strobe(1'b0);
      for (int i = 0; i < 4; i++) strobe(1'b1);
      check("mid_busy", 32'(m_busy), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_busy",  32'(m_busy),  32'h0);
      check("mid_rst_valid", 32'(m_valid), 32'h0);
      rst = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      check("mid_valid", 32'(m_valid), 32'h1);
      check("mid_data",  32'(m_data),  32'h5A);
      check("mid_perr",  32'(m_perr),  32'h0);
      check("mid_ferr",  32'(m_ferr),  32'h0);
      check("mid_cnt",   32'(m_cnt),   32'h0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
